// File: rtl/beer_draft_pkg.sv
// beer_draft_pkg: state codes and default thresholds shared by the beer tap controller.
// Rev 1.0 -- initial release. Optional input synchronizer macro: BEER_INPUT_SYNC_EN.
`default_nettype none

package beer_draft_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'h0,
    ST_READY = 4'h1,
    ST_POUR  = 4'h2,
    ST_PAUSE = 4'h3,
    ST_DONE  = 4'h4,
    ST_FAULT = 4'hF
  } state_t;

  localparam int unsigned C_FULL_LEVEL   = 6;
  localparam int unsigned C_POUR_TIMEOUT = 200;

endpackage

`default_nettype wire

// File: rtl/beer_edge_detect.sv
// beer_edge_detect: optional two-flop synchronizer (BEER_INPUT_SYNC_EN) plus rising-edge pulse.
// Rev 1.0 -- initial release.
`default_nettype none

module beer_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_in,
  output logic o_pulse
);

  logic w_level;
  logic r_prev;

`ifdef BEER_INPUT_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_level = r_sync2;
`else
  assign w_level = i_in;
`endif

  // Previous level resets low so a button already held at reset release yields one pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= w_level;
  end

  assign o_pulse = w_level & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/beer_draft_controller.sv
// beer_draft_controller: beer tap FSM with cumulative pour timer and registered valve/display.
// Rev 1.0 -- initial release. Optional input synchronizer macro: BEER_INPUT_SYNC_EN.
`default_nettype none

module beer_draft_controller
  import beer_draft_pkg::*;
#(
  parameter int unsigned LEVEL_W      = 3,
  parameter int unsigned FULL_LEVEL   = C_FULL_LEVEL,
  parameter int unsigned POUR_TIMEOUT = C_POUR_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               next,
  input  logic               draft,
  input  logic [LEVEL_W-1:0] beer_level,
  output logic               beer,
  output logic [3:0]         state_display
);

  localparam int unsigned   TW           = (POUR_TIMEOUT > 2) ? $clog2(POUR_TIMEOUT) : 1;
  localparam logic [TW-1:0] C_TIMER_LAST = TW'(POUR_TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic          w_next_pulse;
  logic          w_draft;
  logic          w_full;
  logic          w_timeout;

  beer_edge_detect u_next_edge (
    .clk     (clk),
    .reset   (reset),
    .i_in    (next),
    .o_pulse (w_next_pulse)
  );

`ifdef BEER_INPUT_SYNC_EN
  logic r_draft_s1;
  logic r_draft_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_draft_s1 <= 1'b0;
      r_draft_s2 <= 1'b0;
    end else begin
      r_draft_s1 <= draft;
      r_draft_s2 <= r_draft_s1;
    end
  end

  assign w_draft = r_draft_s2;
`else
  assign w_draft = draft;
`endif

  assign w_full    = (32'(beer_level) >= FULL_LEVEL);
  assign w_timeout = (r_timer == C_TIMER_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_next_pulse) w_state_nxt = ST_READY;
      ST_READY: begin
        if (w_draft && w_full)  w_state_nxt = ST_DONE;
        else if (w_draft)       w_state_nxt = ST_POUR;
        else if (w_next_pulse)  w_state_nxt = ST_IDLE;
      end
      ST_POUR: begin
        if (w_full)             w_state_nxt = ST_DONE;
        else if (w_timeout)     w_state_nxt = ST_FAULT;
        else if (!w_draft)      w_state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (w_draft)            w_state_nxt = ST_POUR;
        else if (w_next_pulse)  w_state_nxt = ST_DONE;
      end
      ST_DONE:  if (w_next_pulse) w_state_nxt = ST_IDLE;
      ST_FAULT: if (w_next_pulse) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are loaded from the next-state value so they track r_state with no extra lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      beer          <= 1'b0;
      state_display <= 4'h0;
    end else begin
      r_state       <= w_state_nxt;
      beer          <= (w_state_nxt == ST_POUR);
      state_display <= w_state_nxt;
      case (r_state)
        ST_IDLE, ST_READY: r_timer <= '0;
        ST_POUR:           if (r_timer != C_TIMER_LAST) r_timer <= r_timer + TW'(1);
        default:           r_timer <= r_timer;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_beer_draft_controller.sv
// tb_beer_draft_controller: directed + random stimulus checked against a cycle-level tap model.
// Rev 1.0 -- initial release. Honours BEER_INPUT_SYNC_EN by delaying model inputs two cycles.
`default_nettype none

module tb_beer_draft_controller;

  localparam int unsigned C_LEVEL_W = 3;
  localparam int unsigned C_FULL    = 6;
  localparam int unsigned C_TIMEOUT = 20;
`ifdef BEER_INPUT_SYNC_EN
  localparam bit C_SYNC = 1'b1;
`else
  localparam bit C_SYNC = 1'b0;
`endif

  localparam int S_IDLE = 0, S_READY = 1, S_POUR = 2, S_PAUSE = 3, S_DONE = 4, S_FAULT = 15;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 next;
  logic                 draft;
  logic [C_LEVEL_W-1:0] beer_level;
  logic                 beer;
  logic [3:0]           state_display;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_state;
  int m_pour_cycles;
  bit m_next_prev;
  bit h_n[2];
  bit h_d[2];

  beer_draft_controller #(
    .LEVEL_W      (C_LEVEL_W),
    .FULL_LEVEL   (C_FULL),
    .POUR_TIMEOUT (C_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .next          (next),
    .draft         (draft),
    .beer_level    (beer_level),
    .beer          (beer),
    .state_display (state_display)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_state       = S_IDLE;
    m_pour_cycles = 0;
    m_next_prev   = 1'b0;
    h_n[0] = 1'b0; h_n[1] = 1'b0;
    h_d[0] = 1'b0; h_d[1] = 1'b0;
  endfunction

  function automatic void model_update(bit n, bit d, int lvl);
    bit en, ed, pulse, full;
    int nxt;
    if (C_SYNC) begin
      en = h_n[1]; ed = h_d[1];
      h_n[1] = h_n[0]; h_d[1] = h_d[0];
      h_n[0] = n;      h_d[0] = d;
    end else begin
      en = n; ed = d;
    end
    pulse       = en && !m_next_prev;
    m_next_prev = en;
    full        = (lvl >= int'(C_FULL));
    nxt         = m_state;
    if (m_state == S_IDLE || m_state == S_READY) m_pour_cycles = 0;
    if (m_state == S_POUR && m_pour_cycles < int'(C_TIMEOUT)) m_pour_cycles++;
    case (m_state)
      S_IDLE:  if (pulse) nxt = S_READY;
      S_READY: nxt = (ed && full) ? S_DONE : ed ? S_POUR : pulse ? S_IDLE : S_READY;
      S_POUR:  nxt = full ? S_DONE : (m_pour_cycles >= int'(C_TIMEOUT)) ? S_FAULT : !ed ? S_PAUSE : S_POUR;
      S_PAUSE: nxt = ed ? S_POUR : pulse ? S_DONE : S_PAUSE;
      default: if (pulse) nxt = S_IDLE;
    endcase
    m_state = nxt;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit n, input bit d, input int lvl);
    @(negedge clk);
    next       = n;
    draft      = d;
    beer_level = C_LEVEL_W'(lvl);
    @(posedge clk);
    if (reset) model_reset();
    else       model_update(n, d, lvl);
    #1;
    check("state", state_display, 4'(m_state));
    check("beer", {3'b000, beer}, {3'b000, (m_state == S_POUR)});
  endtask

  initial begin
    reset = 1'b1; next = 1'b0; draft = 1'b1; beer_level = '0;
    model_reset();
    repeat (3) step(0, 1, 0);
    check("reset_display", state_display, 4'h0);
    check("reset_beer", {3'b000, beer}, 4'h0);
    reset = 1'b0;
    repeat (4) step(0, 1, 0);

    // Arm, pour, fill, rearm
    step(1, 0, 0); step(0, 1, 2); step(0, 1, 2); step(0, 1, 2);
    step(0, 1, 6); step(0, 1, 6); step(0, 0, 6); step(1, 0, 6); step(0, 0, 0); step(0, 0, 0);

    // Pause / resume / abort
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 3); step(0, 0, 3); step(0, 0, 3); step(1, 0, 3); step(0, 0, 3); step(0, 0, 0);
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);

    // Timeout with draft held on an empty glass
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    repeat (C_TIMEOUT + 3) step(0, 1, 0);
`ifndef BEER_INPUT_SYNC_EN
    check("timeout_state", state_display, 4'hF);
    check("timeout_beer", {3'b000, beer}, 4'h0);
`endif
    step(1, 1, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

    // Held next only arms once; already-full glass goes straight to DONE
    repeat (50) step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0);
    repeat (4) step(0, 1, 7);
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

    // Asynchronous reset mid-pour
    step(1, 0, 1); step(0, 1, 1); step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
    #2 reset = 1'b1;
    #1;
    check("async_display", state_display, 4'h0);
    check("async_beer", {3'b000, beer}, 4'h0);
    model_reset();
    step(0, 1, 1);
    reset = 1'b0;
    step(0, 0, 0);

    // Random stimulus
    for (int i = 0; i < 800; i++) begin
      bit n, d;
      int lvl;
      n   = ($urandom_range(0, 3) == 0);
      d   = ($urandom_range(0, 3) != 0);
      lvl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 5));
      step(n, d, lvl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
